// File: rtl/divide_pipeline_hs_if.sv
// divide_pipeline_hs_if: operand/result valid-ready handshake bundle for the pipelined divider
interface divide_pipeline_hs_if #(
  parameter int DATA_WD = 8,
  parameter int FRAC_WD = 8,
  parameter int TAG_WD  = 4
);
  logic                       in_val;
  logic                       in_rdy;
  logic [DATA_WD-1:0]         in_a;
  logic [DATA_WD-1:0]         in_b;
  logic [TAG_WD-1:0]          in_tag;
  logic                       out_val;
  logic                       out_rdy;
  logic [DATA_WD+FRAC_WD-1:0] out_c;
  logic                       out_dz;
  logic [TAG_WD-1:0]          out_tag;
  modport master (
    output in_val, in_a, in_b, in_tag, out_rdy,
    input  in_rdy, out_val, out_c, out_dz, out_tag
  );
  modport slave (
    input  in_val, in_a, in_b, in_tag, out_rdy,
    output in_rdy, out_val, out_c, out_dz, out_tag
  );
endinterface

// File: rtl/divide_pipeline_hs.sv
// divide_pipeline_hs: Newton-Raphson reciprocal pipeline giving a/b as I{DATA_WD}F{FRAC_WD}, one result per cycle
module divide_pipeline_hs #(
  parameter int DATA_WD  = 8,
  parameter int FRAC_WD  = 8,
  parameter int INN_WD   = 24,
  parameter int NUMB_ITR = 12,
  parameter int TAG_WD   = 4
) (
  input logic clk,
  input logic rstn,
  divide_pipeline_hs_if.slave io
);
  localparam int QW = DATA_WD + INN_WD;
  localparam int CW = DATA_WD + FRAC_WD;
  localparam int L  = NUMB_ITR - 1;
  localparam logic [INN_WD-1:0] T_IN = INN_WD'(1) << (INN_WD - DATA_WD);
  // One iteration t*(2 - b*t); rounding can reach 1.0 when b = 1, so clamp below it
  function automatic logic [INN_WD-1:0] nr_step(input logic [DATA_WD-1:0] b, input logic [INN_WD-1:0] t);
    logic [INN_WD:0]   k;
    logic [2*INN_WD:0] p;
    logic [INN_WD+1:0] r;
    k = -((INN_WD+1)'(b) * (INN_WD+1)'(t));
    p = (2*INN_WD+1)'(t) * (2*INN_WD+1)'(k);
    r = (INN_WD+2)'(((p >> (INN_WD-1)) + (2*INN_WD+1)'(1)) >> 1);
    return |r[INN_WD+1:INN_WD] ? '1 : r[INN_WD-1:0];
  endfunction
  logic               en;
  logic               s_val [NUMB_ITR];
  logic               s_dz  [NUMB_ITR];
  logic [DATA_WD-1:0] s_a   [NUMB_ITR];
  logic [DATA_WD-1:0] s_b   [NUMB_ITR];
  logic [TAG_WD-1:0]  s_tag [NUMB_ITR];
  logic [INN_WD-1:0]  s_t   [NUMB_ITR];
  logic               p_val [NUMB_ITR];
  logic               p_dz  [NUMB_ITR];
  logic [DATA_WD-1:0] p_a   [NUMB_ITR];
  logic [DATA_WD-1:0] p_b   [NUMB_ITR];
  logic [TAG_WD-1:0]  p_tag [NUMB_ITR];
  logic [INN_WD-1:0]  p_t   [NUMB_ITR];
  logic [INN_WD-1:0]  tn    [NUMB_ITR];
  logic               q_val;
  logic               q_dz;
  logic [TAG_WD-1:0]  q_tag;
  logic [QW-1:0]      q_prod;
  assign en = ~io.out_val | io.out_rdy;
  assign io.in_rdy = en;
  // Each stage register holds the estimate entering its iteration; the last iteration feeds the product stage
  for (genvar i = 0; i < NUMB_ITR; i++) begin : g_stage
    assign tn[i] = nr_step(s_b[i], s_t[i]);
    if (i == 0) begin : g_head
      assign p_val[i] = io.in_val;
      assign p_dz[i]  = io.in_b == '0;
      assign p_a[i]   = io.in_a;
      assign p_b[i]   = io.in_b;
      assign p_tag[i] = io.in_tag;
      assign p_t[i]   = T_IN;
    end else begin : g_link
      assign p_val[i] = s_val[i-1];
      assign p_dz[i]  = s_dz[i-1];
      assign p_a[i]   = s_a[i-1];
      assign p_b[i]   = s_b[i-1];
      assign p_tag[i] = s_tag[i-1];
      assign p_t[i]   = tn[i-1];
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int n = 0; n < NUMB_ITR; n++) begin
        s_val[n] <= 1'b0;
        s_dz[n]  <= 1'b0;
        s_a[n]   <= '0;
        s_b[n]   <= '0;
        s_tag[n] <= '0;
        s_t[n]   <= '0;
      end
      q_val      <= 1'b0;
      q_dz       <= 1'b0;
      q_tag      <= '0;
      q_prod     <= '0;
      io.out_val <= 1'b0;
      io.out_dz  <= 1'b0;
      io.out_tag <= '0;
      io.out_c   <= '0;
    end else if (en) begin
      for (int n = 0; n < NUMB_ITR; n++) begin
        s_val[n] <= p_val[n];
        if (p_val[n]) begin
          s_dz[n]  <= p_dz[n];
          s_a[n]   <= p_a[n];
          s_b[n]   <= p_b[n];
          s_tag[n] <= p_tag[n];
          s_t[n]   <= p_t[n];
        end
      end
      q_val <= s_val[L];
      if (s_val[L]) begin
        q_dz   <= s_dz[L];
        q_tag  <= s_tag[L];
        q_prod <= QW'(s_a[L]) * QW'(tn[L]);
      end
      io.out_val <= q_val;
      if (q_val) begin
        io.out_dz  <= q_dz;
        io.out_tag <= q_tag;
        io.out_c   <= q_dz ? '1 : CW'(((q_prod >> (INN_WD-FRAC_WD-1)) + QW'(1)) >> 1);
      end
    end
endmodule

// File: tb/tb_divide_pipeline_hs.sv
// tb_divide_pipeline_hs: directed vectors plus streaming, stall and reset sequences with an in-order scoreboard
module tb_divide_pipeline_hs;
  localparam int DW = 8, FW = 8, TW = 4, LAT = 13;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  divide_pipeline_hs_if #(.DATA_WD(DW), .FRAC_WD(FW), .TAG_WD(TW)) io ();
  divide_pipeline_hs dut (.clk(clk), .rstn(rstn), .io(io));
  typedef struct {int a; int b; int tag; int c; int dz;} vec_t;
  typedef struct {int c; int dz; int tag;} exp_t;
  vec_t vecs [12];
  exp_t sb [$];
  exp_t me;
  int total = 0, bad = 0, nout = 0, ncyc = 0, t_first = 0, t_last = 0;
  int cur_c = 0, cur_dz = 0;
  task automatic chk(input string name, input bit ok, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask
  function automatic int ref_c(input int a, input int b);
    return b == 0 ? 'hFFFF : (a * 512 / b + 1) / 2;
  endfunction
  always @(negedge clk) begin
    ncyc++;
    if (rstn) begin
      if (io.out_val && io.out_rdy) begin
        if (sb.size() == 0) chk("spurious_out", 1'b0, int'(io.out_tag), -1);
        else begin
          me = sb.pop_front();
          chk("out_tag", int'(io.out_tag) == me.tag, int'(io.out_tag), me.tag);
          chk("out_dz", int'(io.out_dz) == me.dz, int'(io.out_dz), me.dz);
          chk("out_c", me.dz != 0 ? int'(io.out_c) == me.c
                                  : (int'(io.out_c) - me.c <= 1 && me.c - int'(io.out_c) <= 1),
              int'(io.out_c), me.c);
        end
        if (nout == 0) t_first = ncyc;
        t_last = ncyc;
        nout++;
      end
      if (io.in_val && io.in_rdy) sb.push_back('{cur_c, cur_dz, int'(io.in_tag)});
    end
  end
  task automatic send(input int a, input int b, input int tg, input int c, input int dz);
    bit acc = 1'b0;
    io.in_a = DW'(a);
    io.in_b = DW'(b);
    io.in_tag = TW'(tg);
    cur_c = c;
    cur_dz = dz;
    io.in_val = 1'b1;
    for (int w = 0; w < 200 && !acc; w++) begin
      @(negedge clk);
      acc = io.in_rdy;
      @(posedge clk);
      #1;
    end
    io.in_val = 1'b0;
    if (!acc) chk("send_timeout", 1'b0, 0, 1);
  endtask
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!io.out_val && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic drain(input string name);
    for (int w = 0; w < 100 && sb.size() > 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk(name, sb.size() == 0, sb.size(), 0);
  endtask
  initial begin
    int cyc, seen;
    int hold_c, hold_t;
    vecs[0]  = '{100,   3,  1, 'h2155, 0};
    vecs[1]  = '{255,   1,  2, 'hFF00, 0};
    vecs[2]  = '{  1, 255,  3, 'h0001, 0};
    vecs[3]  = '{  0,   7,  4, 'h0000, 0};
    vecs[4]  = '{255, 255,  5, 'h0100, 0};
    vecs[5]  = '{ 37,   0,  6, 'hFFFF, 1};
    vecs[6]  = '{ 10,   2,  7, 'h0500, 0};
    vecs[7]  = '{200,   7,  8, 'h1C92, 0};
    vecs[8]  = '{ 50,   9,  9, 'h058E, 0};
    vecs[9]  = '{128,   2, 10, 'h4000, 0};
    vecs[10] = '{255,   2, 11, 'h7F80, 0};
    vecs[11] = '{  3, 128, 12, 'h0006, 0};
    io.in_val = 1'b0;
    io.in_a = '0;
    io.in_b = '0;
    io.in_tag = '0;
    io.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", io.out_val == 1'b0, int'(io.out_val), 0);
    chk("rst_out_c", io.out_c == '0, int'(io.out_c), 0);
    chk("rst_out_dz", io.out_dz == 1'b0, int'(io.out_dz), 0);
    chk("rst_out_tag", io.out_tag == '0, int'(io.out_tag), 0);
    chk("rst_in_rdy", io.in_rdy == 1'b1, int'(io.in_rdy), 1);
    rstn = 1'b1;
    io.out_rdy = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].c, vecs[i].dz);
      wait_out(cyc);
      chk("latency", cyc == LAT, cyc, LAT);
      chk("in_rdy_idle", io.in_rdy == 1'b1, int'(io.in_rdy), 1);
      @(posedge clk);
      #1;
    end
    drain("vec_drain");
    nout = 0;
    for (int i = 0; i < 20; i++) begin
      int a = int'($urandom_range(0, 255));
      int b = int'($urandom_range(1, 255));
      send(a, b, i % 16, ref_c(a, b), 0);
    end
    drain("b2b_drain");
    chk("b2b_count", nout == 20, nout, 20);
    chk("b2b_consecutive", t_last - t_first + 1 == 20, t_last - t_first + 1, 20);
    nout = 0;
    fork
      for (int i = 0; i < 20; i++) begin
        int a = int'($urandom_range(0, 255));
        int b = int'($urandom_range(0, 255));
        send(a, b, (i + 3) % 16, ref_c(a, b), b == 0 ? 1 : 0);
      end
      begin
        repeat (16) @(posedge clk);
        #1;
        io.out_rdy = 1'b0;
        @(negedge clk);
        hold_c = int'(io.out_c);
        hold_t = int'(io.out_tag);
        chk("stall_out_val", io.out_val == 1'b1, int'(io.out_val), 1);
        chk("stall_in_rdy", io.in_rdy == 1'b0, int'(io.in_rdy), 0);
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_rdy", io.in_rdy == 1'b0, int'(io.in_rdy), 0);
          chk("stall_c_hold", int'(io.out_c) == hold_c, int'(io.out_c), hold_c);
          chk("stall_tag_hold", int'(io.out_tag) == hold_t, int'(io.out_tag), hold_t);
        end
        @(posedge clk);
        #1;
        io.out_rdy = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", nout == 20, nout, 20);
    io.out_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) send(60 + i, 5, i, ref_c(60 + i, 5), 0);
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_out_val", io.out_val == 1'b1, int'(io.out_val), 1);
    rstn = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_out_val", io.out_val == 1'b0, int'(io.out_val), 0);
    chk("mid_rst_out_c", io.out_c == '0, int'(io.out_c), 0);
    chk("mid_rst_out_dz", io.out_dz == 1'b0, int'(io.out_dz), 0);
    chk("mid_rst_out_tag", io.out_tag == '0, int'(io.out_tag), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    io.out_rdy = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (io.out_val) seen++;
    end
    chk("no_out_after_rst", seen == 0, seen, 0);
    @(posedge clk);
    #1;
    send(9, 4, 13, 'h0240, 0);
    wait_out(cyc);
    chk("post_rst_latency", cyc == LAT, cyc, LAT);
    drain("post_rst_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
